// File: rtl/rx_pol_detect_comma_restore_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rx_pol_pkg
//  Description : Comma code points, FSM state type and comma-restore helper
//                shared by the RX polarity detect / comma restore block.
//  Revision    : 1.0 - initial release
// ============================================================================
package rx_pol_pkg;

  // Standard K28.5 running-disparity pair seen by the 8b10b decoder
  localparam logic [9:0] ORI_COMMA_POS     = 10'b01_0111_1100;
  localparam logic [9:0] ORI_COMMA_NEG     = ~ORI_COMMA_POS;

  // Polarity markers inserted by the TX side (K28.2+ / K28.6-)
  localparam logic [9:0] REP_COMMA_POS     = 10'b10_1011_1100;
  localparam logic [9:0] REP_COMMA_NEG     = 10'b10_0100_0011;

  // Same markers as they arrive over a bit-inverted line
  localparam logic [9:0] REP_COMMA_POS_INV = ~REP_COMMA_POS;
  localparam logic [9:0] REP_COMMA_NEG_INV = ~REP_COMMA_NEG;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  // Strip the line polarity from a marker and map it back to K28.5+/-
  function automatic logic [9:0] restore_comma(input logic [9:0] word, input logic p);
    logic [9:0] w_strip;
    w_strip = p ? ~word : word;
    return (w_strip == REP_COMMA_POS) ? ORI_COMMA_POS : ORI_COMMA_NEG;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_pol_detect_comma_restore_if.sv
`default_nettype none
// ============================================================================
//  Module      : rx_pol_detect_comma_restore_if
//  Description : Word stream into and out of the polarity detect / comma
//                restore block, plus its lock status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rx_pol_detect_comma_restore_if;
  logic       i_en;
  logic       i_vld;
  logic [9:0] i_data;
  logic       o_vld;
  logic [9:0] o_data;
  logic       o_comma;
  logic       o_lock;
  logic       o_inv;
  logic       o_pol_flip;

  modport master (
    output i_en, i_vld, i_data,
    input  o_vld, o_data, o_comma, o_lock, o_inv, o_pol_flip
  );

  modport slave (
    input  i_en, i_vld, i_data,
    output o_vld, o_data, o_comma, o_lock, o_inv, o_pol_flip
  );
endinterface
`default_nettype wire

// File: rtl/rx_pol_detect_comma_restore_cls.sv
`default_nettype none
// ============================================================================
//  Module      : rx_pol_comma_cls
//  Description : Combinational classifier: flags polarity markers and reports
//                whether the marker arrived normal (0) or inverted (1).
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_pol_comma_cls
  import rx_pol_pkg::*;
(
  input  wire logic [9:0] i_word,
  output logic            o_is_marker,
  output logic            o_pol
);

  logic w_norm;
  logic w_inv;

  assign w_norm      = (i_word == REP_COMMA_POS) || (i_word == REP_COMMA_NEG);
  assign w_inv       = (i_word == REP_COMMA_POS_INV) || (i_word == REP_COMMA_NEG_INV);
  assign o_is_marker = w_norm | w_inv;
  assign o_pol       = w_inv;

endmodule
`default_nettype wire

// File: rtl/rx_pol_detect_comma_restore.sv
`default_nettype none
// ============================================================================
//  Module      : rx_pol_detect_comma_restore
//  Description : Locks line polarity from K28.2+/K28.6- markers, un-inverts
//                data and restores markers to K28.5 with 1-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_pol_detect_comma_restore
  import rx_pol_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int FLIP_CNT   = 3,
  parameter int WD_TIMEOUT = 1024
) (
  input  wire logic                     i_clk,
  input  wire logic                     i_rst,
  rx_pol_detect_comma_restore_if.slave  bus
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam int ERR_W = $clog2(FLIP_CNT + 1);
  localparam int WD_W  = $clog2(WD_TIMEOUT + 1);

  // Last value before the threshold: the word that hits it acts instead of counting
  localparam logic [CNT_W-1:0] C_LOCK_LAST = CNT_W'(LOCK_CNT - 1);
  localparam logic [ERR_W-1:0] C_FLIP_LAST = ERR_W'(FLIP_CNT - 1);
  localparam logic [WD_W-1:0]  C_WD_LAST   = WD_W'(WD_TIMEOUT - 1);
  localparam logic [WD_W-1:0]  C_WD_MAX    = WD_W'(WD_TIMEOUT);

  state_e           r_state, w_state_nxt;
  logic             r_cand,  w_cand_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [ERR_W-1:0] r_err,   w_err_nxt;
  logic [WD_W-1:0]  r_wd,    w_wd_nxt;
  logic             r_inv,   w_inv_nxt;
  logic             w_flip_nxt;

  logic             w_is_marker;
  logic             w_pol;
  logic [9:0]       w_data_d;
  logic             w_comma_d;

  logic             r_o_vld;
  logic [9:0]       r_o_data;
  logic             r_o_comma;
  logic             r_o_flip;

  rx_pol_comma_cls u_cls (
    .i_word      (bus.i_data),
    .o_is_marker (w_is_marker),
    .o_pol       (w_pol)
  );

  // State register and lock/flip/watchdog counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= SEARCH;
      r_cand  <= 1'b0;
      r_cnt   <= '0;
      r_err   <= '0;
      r_wd    <= '0;
      r_inv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_wd    <= w_wd_nxt;
      r_inv   <= w_inv_nxt;
    end
  end

  // Next-state: only valid words advance detection; disable forces a clean restart
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_wd_nxt    = r_wd;
    w_inv_nxt   = r_inv;
    w_flip_nxt  = 1'b0;
    if (!bus.i_en) begin
      w_state_nxt = SEARCH;
      w_cand_nxt  = 1'b0;
      w_cnt_nxt   = '0;
      w_err_nxt   = '0;
      w_wd_nxt    = '0;
      w_inv_nxt   = 1'b0;
    end else if (bus.i_vld) begin
      if (w_is_marker) begin
        w_wd_nxt = '0;
        case (r_state)
          SEARCH: begin
            w_cand_nxt = w_pol;
            if (LOCK_CNT == 1) begin
              w_state_nxt = LOCKED;
              w_inv_nxt   = w_pol;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = CONFIRM;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
          CONFIRM: begin
            if (w_pol != r_cand) begin
              w_cand_nxt = w_pol;
              w_cnt_nxt  = CNT_W'(1);
            end else if (r_cnt == C_LOCK_LAST) begin
              w_state_nxt = LOCKED;
              w_inv_nxt   = r_cand;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
          LOCKED: begin
            if (w_pol == r_inv) begin
              w_err_nxt = '0;
            end else if (r_err == C_FLIP_LAST) begin
              w_inv_nxt  = w_pol;
              w_err_nxt  = '0;
              w_flip_nxt = 1'b1;
            end else begin
              w_err_nxt = r_err + 1'b1;
            end
          end
          default: w_state_nxt = SEARCH;
        endcase
      end else if (r_state != SEARCH) begin
        // Too long without a marker: fall back to search but keep the polarity
        if (r_wd >= C_WD_LAST) begin
          w_state_nxt = SEARCH;
          w_cnt_nxt   = '0;
          w_err_nxt   = '0;
          w_wd_nxt    = '0;
        end else if (r_wd != C_WD_MAX) begin
          w_wd_nxt = r_wd + 1'b1;
        end
      end
    end
  end

  // Output word: markers ignore r_inv, data uses the polarity held before this word
  always_comb begin
    w_data_d  = bus.i_data;
    w_comma_d = 1'b0;
    if (bus.i_en) begin
      if (w_is_marker) begin
        w_data_d  = restore_comma(bus.i_data, w_pol);
        w_comma_d = 1'b1;
      end else begin
        w_data_d  = r_inv ? ~bus.i_data : bus.i_data;
      end
    end
  end

  // One-cycle output register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_o_vld   <= 1'b0;
      r_o_data  <= '0;
      r_o_comma <= 1'b0;
      r_o_flip  <= 1'b0;
    end else begin
      r_o_vld   <= bus.i_vld;
      if (bus.i_vld) begin
        r_o_data <= w_data_d;
      end
      r_o_comma <= bus.i_vld & w_comma_d;
      r_o_flip  <= w_flip_nxt;
    end
  end

  assign bus.o_vld      = r_o_vld;
  assign bus.o_data     = r_o_data;
  assign bus.o_comma    = r_o_comma;
  assign bus.o_lock     = (r_state == LOCKED);
  assign bus.o_inv      = r_inv;
  assign bus.o_pol_flip = r_o_flip;

endmodule
`default_nettype wire

// File: tb/tb_rx_pol_detect_comma_restore.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_pol_detect_comma_restore
//  Description : Self-checking bench: directed scenarios plus random word
//                streams compared against a behavioural polarity model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_pol_detect_comma_restore;

  localparam logic [9:0] K_ORI_P  = 10'b0101111100;
  localparam logic [9:0] K_ORI_N  = 10'b1010000011;
  localparam logic [9:0] K_MK_P   = 10'b1010111100;
  localparam logic [9:0] K_MK_N   = 10'b1001000011;
  localparam int         LOCK_N   = 4;
  localparam int         FLIP_N   = 3;
  localparam int         WD_N     = 1024;

  logic clk;
  logic rst;
  rx_pol_detect_comma_restore_if bus ();

  rx_pol_detect_comma_restore dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model of the line: lock status, candidate polarity and counts
  bit         m_lock, m_cand_ok, m_cand, m_inv;
  int         m_cnt, m_err, m_wd;
  logic       e_vld, e_comma, e_lock, e_inv, e_flip, e_chk_data;
  logic [9:0] e_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit classify(input logic [9:0] d, output bit p);
    p = (d == ~K_MK_P) || (d == ~K_MK_N);
    return (d == K_MK_P) || (d == K_MK_N) || p;
  endfunction

  function automatic void clear_model();
    m_lock = 0; m_cand_ok = 0; m_cand = 0; m_cnt = 0; m_err = 0; m_wd = 0;
  endfunction

  function automatic void model(input logic r, input logic en, input logic vld, input logic [9:0] d);
    bit mk, p;
    logic [9:0] u;
    e_flip = 0;
    e_chk_data = 0;
    if (r) begin
      clear_model(); m_inv = 0;
      e_vld = 0; e_data = '0; e_comma = 0; e_chk_data = 1;
    end else begin
      e_vld = vld;
      if (!en) begin
        clear_model(); m_inv = 0;
        if (vld) begin e_data = d; e_comma = 0; e_chk_data = 1; end
      end else if (vld) begin
        e_chk_data = 1;
        mk = classify(d, p);
        if (mk) begin
          u = p ? ~d : d;
          e_data  = (u == K_MK_P) ? K_ORI_P : K_ORI_N;
          e_comma = 1;
          m_wd = 0;
          if (m_lock) begin
            if (p == m_inv) m_err = 0;
            else begin
              m_err++;
              if (m_err >= FLIP_N) begin m_inv = p; m_err = 0; e_flip = 1; end
            end
          end else begin
            if (!m_cand_ok || p != m_cand) begin m_cand = p; m_cnt = 1; m_cand_ok = 1; end
            else m_cnt++;
            if (m_cnt >= LOCK_N) begin
              m_lock = 1; m_inv = m_cand; m_cand_ok = 0; m_cnt = 0;
            end
          end
        end else begin
          e_data  = m_inv ? ~d : d;
          e_comma = 0;
          if (m_lock || m_cand_ok) begin
            m_wd++;
            if (m_wd >= WD_N) clear_model();
          end
        end
      end
    end
    e_lock = m_lock;
    e_inv  = m_inv;
  endfunction

  // Apply one cycle of inputs, then compare the registered outputs
  task automatic step(input logic r, input logic en, input logic vld, input logic [9:0] d);
    rst = r; bus.i_en = en; bus.i_vld = vld; bus.i_data = d;
    model(r, en, vld, d);
    @(posedge clk);
    #1;
    check("vld", {31'd0, bus.o_vld}, {31'd0, e_vld});
    if (e_chk_data) begin
      check("data",  {22'd0, bus.o_data}, {22'd0, e_data});
      check("comma", {31'd0, bus.o_comma}, {31'd0, e_comma});
    end
    check("lock", {31'd0, bus.o_lock},     {31'd0, e_lock});
    check("inv",  {31'd0, bus.o_inv},      {31'd0, e_inv});
    check("flip", {31'd0, bus.o_pol_flip}, {31'd0, e_flip});
  endtask

  function automatic logic [9:0] rand_data();
    logic [9:0] d;
    bit p;
    d = 10'($urandom_range(0, 1023));
    while (classify(d, p)) d = 10'($urandom_range(0, 1023));
    return d;
  endfunction

  function automatic logic [9:0] marker(input bit p);
    logic [9:0] b;
    b = ($urandom_range(0, 1) == 0) ? K_MK_P : K_MK_N;
    return p ? ~b : b;
  endfunction

  initial begin
    bit lp;
    rst = 1'b1; bus.i_en = 1'b0; bus.i_vld = 1'b0; bus.i_data = '0;

    // 1: reset state, then normal-polarity lock
    step(1, 0, 1, K_MK_P);
    check("rst_lock", {31'd0, bus.o_lock}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, K_MK_P);
      check("t1_data", {22'd0, bus.o_data}, {22'd0, K_ORI_P});
    end
    check("t1_lock", {31'd0, bus.o_lock}, 32'd1);
    check("t1_inv",  {31'd0, bus.o_inv},  32'd0);

    // 2: inverted line locks inverted and complements data
    step(1, 1, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 10'b0101000011);
    check("t2_data_c", {22'd0, bus.o_data}, {22'd0, K_ORI_P});
    step(0, 1, 1, 10'h155);
    check("t2_lock", {31'd0, bus.o_lock}, 32'd1);
    check("t2_inv",  {31'd0, bus.o_inv},  32'd1);
    check("t2_data", {22'd0, bus.o_data}, 32'h2AA);

    // 3: flip only after three consecutive opposite markers
    step(1, 1, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, K_MK_N);
    step(0, 1, 1, ~K_MK_P);
    step(0, 1, 1, ~K_MK_N);
    check("t3_noflip", {31'd0, bus.o_pol_flip}, 32'd0);
    step(0, 1, 1, K_MK_P);
    step(0, 1, 1, ~K_MK_P);
    step(0, 1, 1, ~K_MK_P);
    check("t3_inv_pre", {31'd0, bus.o_inv}, 32'd0);
    step(0, 1, 1, ~K_MK_N);
    check("t3_flip", {31'd0, bus.o_pol_flip}, 32'd1);
    check("t3_inv",  {31'd0, bus.o_inv},      32'd1);
    step(0, 1, 0, '0);
    check("t3_pulse_end", {31'd0, bus.o_pol_flip}, 32'd0);

    // 4: watchdog drops lock on the 1024th data word
    step(1, 1, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, K_MK_P);
    for (int i = 0; i < WD_N - 1; i++) begin
      step(0, 1, 1, rand_data());
      if ((i % 7) == 0) step(0, 1, 0, rand_data());
    end
    check("t4_lock_held", {31'd0, bus.o_lock}, 32'd1);
    step(0, 1, 1, rand_data());
    check("t4_lock_drop", {31'd0, bus.o_lock}, 32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, K_MK_N);
    check("t4_no_relock", {31'd0, bus.o_lock}, 32'd0);
    step(0, 1, 1, K_MK_N);
    check("t4_relock", {31'd0, bus.o_lock}, 32'd1);

    // 5: disabled block passes words through untouched, gaps included
    for (int i = 0; i < 6; i++) begin
      step(0, 0, (i % 2) == 0, K_MK_P);
      if ((i % 2) == 0) begin
        check("t5_data",  {22'd0, bus.o_data}, {22'd0, K_MK_P});
        check("t5_comma", {31'd0, bus.o_comma}, 32'd0);
      end
      check("t5_lock", {31'd0, bus.o_lock}, 32'd0);
    end

    // 6: reset mid-confirm discards the partial count
    for (int i = 0; i < 3; i++) step(0, 1, 1, K_MK_P);
    step(1, 1, 1, K_MK_P);
    check("t6_rst_vld", {31'd0, bus.o_vld}, 32'd0);
    step(0, 1, 1, K_MK_P);
    check("t6_nolock", {31'd0, bus.o_lock}, 32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, K_MK_P);
    check("t6_lock", {31'd0, bus.o_lock}, 32'd1);

    // Random streams with a slowly changing dominant line polarity
    lp = 0;
    for (int i = 0; i < 4000; i++) begin
      logic r, en, vld;
      logic [9:0] d;
      if ($urandom_range(0, 299) == 0) lp = ~lp;
      r   = ($urandom_range(0, 599) == 0);
      en  = ($urandom_range(0, 149) != 0);
      vld = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 9) < 4)
        d = marker(($urandom_range(0, 99) < 85) ? lp : ~lp);
      else
        d = rand_data();
      step(r, en, vld, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
